// File: rtl/lfsr_prbs.sv
// lfsr_prbs: Fibonacci LFSR pattern generator plus an independent PRBS checker
// that runs on the same polynomial. Both sit in the i_clk domain.
//
// Optional build macro: LFSR_ERR_INJECT_EN adds i_inject, which inverts
// o_prbs_out for any cycle where i_inject and i_en are both high. The
// generator state is not affected.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_en         generator advance enable
//   i_load       load i_seed_in into the generator (wins over i_en)
//   i_seed_in    seed value for i_load
//   o_state      generator state register
//   o_prbs_out   generator serial output, state MSB
//   o_lockup     one-cycle pulse when the all-zero state is recovered
//   i_inject     (LFSR_ERR_INJECT_EN only) invert o_prbs_out this cycle
//   i_rx_bit     checker input bit
//   i_rx_valid   i_rx_bit qualifier; the checker holds when low
//   i_clr_err    synchronous clear of o_err_count
//   o_synced     checker locked
//   o_err_pulse  one-cycle pulse per counted error
//   o_err_count  saturating error count
//
// Checker states
//   state    | meaning
//   S_HUNT   | shifting WIDTH received bits into the reference register
//   S_VERIFY | comparing received bits to the prediction, SYNC_LEN in a row
//   S_LOCKED | reference free-runs; mismatches are counted as errors

module lfsr_prbs #(
  parameter int unsigned       WIDTH    = 4,
  parameter logic [WIDTH-1:0]  TAPS     = 4'b1100,
  parameter logic [WIDTH-1:0]  SEED     = 4'b0001,
  parameter int unsigned       SYNC_LEN = 8,
  parameter int unsigned       LOSS_THR = 4,
  parameter int unsigned       ERR_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed_in,
  output logic [WIDTH-1:0] o_state,
  output logic             o_prbs_out,
  output logic             o_lockup,
`ifdef LFSR_ERR_INJECT_EN
  input  logic             i_inject,
`endif
  input  logic             i_rx_bit,
  input  logic             i_rx_valid,
  input  logic             i_clr_err,
  output logic             o_synced,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH);
  localparam int unsigned MATCH_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int unsigned MISS_W  = (LOSS_THR > 1) ? $clog2(LOSS_THR) : 1;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } chk_state_t;

  function automatic logic f_fb(input logic [WIDTH-1:0] s);
    return ^(s & TAPS);
  endfunction

  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], f_fb(s)};
  endfunction

  // ---------------- generator ----------------
  logic [WIDTH-1:0] r_state;
  logic             r_lockup;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= SEED;
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= 1'b0;
      if (i_load) begin
        r_state <= i_seed_in;
      end else if (r_state == '0) begin
        r_state  <= SEED;
        r_lockup <= 1'b1;
      end else if (i_en) begin
        r_state <= f_next(r_state);
      end
    end
  end

  assign o_state  = r_state;
  assign o_lockup = r_lockup;

`ifdef LFSR_ERR_INJECT_EN
  assign o_prbs_out = r_state[WIDTH-1] ^ (i_inject & i_en);
`else
  assign o_prbs_out = r_state[WIDTH-1];
`endif

  // ---------------- checker ----------------
  chk_state_t         r_fsm;
  logic [WIDTH-1:0]   r_chk;
  logic [FILL_W-1:0]  r_fill;
  logic [MATCH_W-1:0] r_match;
  logic [MISS_W-1:0]  r_miss;
  logic               r_synced;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_err_count;

  logic [WIDTH-1:0]   w_chk_shift;
  logic               w_pred;
  logic               w_miss;

  assign w_chk_shift = {r_chk[WIDTH-2:0], i_rx_bit};
  assign w_pred      = f_fb(r_chk);
  assign w_miss      = (i_rx_bit != w_pred);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm       <= S_HUNT;
      r_chk       <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_synced    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (i_clr_err) begin
        r_err_count <= '0;
      end
      if (i_rx_valid) begin
        case (r_fsm)
          S_HUNT: begin
            r_chk <= w_chk_shift;
            if (r_fill == FILL_W'(WIDTH - 1)) begin
              r_fill  <= '0;
              r_match <= '0;
              r_fsm   <= S_VERIFY;
            end else begin
              r_fill <= r_fill + 1'b1;
            end
          end
          S_VERIFY: begin
            r_chk <= w_chk_shift;
            // an all-zero reference would predict zeros forever
            if (w_miss || (w_chk_shift == '0)) begin
              r_fill <= '0;
              r_fsm  <= S_HUNT;
            end else if (r_match == MATCH_W'(SYNC_LEN - 1)) begin
              r_miss   <= '0;
              r_synced <= 1'b1;
              r_fsm    <= S_LOCKED;
            end else begin
              r_match <= r_match + 1'b1;
            end
          end
          S_LOCKED: begin
            r_chk <= f_next(r_chk);
            if (w_miss) begin
              // a clear in the same cycle wins and the error is dropped
              if (!i_clr_err) begin
                r_err_pulse <= 1'b1;
                if (r_err_count != '1) begin
                  r_err_count <= r_err_count + 1'b1;
                end
              end
              if (r_miss == MISS_W'(LOSS_THR - 1)) begin
                r_miss   <= '0;
                r_fill   <= '0;
                r_synced <= 1'b0;
                r_fsm    <= S_HUNT;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end else begin
              r_miss <= '0;
            end
          end
          default: begin
            r_fsm <= S_HUNT;
          end
        endcase
      end
    end
  end

  assign o_synced    = r_synced;
  assign o_err_pulse = r_err_pulse;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_prbs.sv
module tb_lfsr_prbs;

  localparam int W        = 4;
  localparam logic [3:0] TAPS = 4'b1100;
  localparam logic [3:0] SEED = 4'b0001;
  localparam int SYNC_LEN = 8;
  localparam int LOSS_THR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en = 1'b0, load = 1'b0, rx_bit = 1'b0, rx_valid = 1'b0, clr_err = 1'b0;
  logic [3:0] seed_in = '0;

  logic [3:0]  state_a, state_b;
  logic        prbs_a, prbs_b, lockup_a, lockup_b;
  logic        synced_a, synced_b, pulse_a, pulse_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  // bench control of the rx source
  bit loopback = 1'b0;
  bit flip = 1'b0;
  bit force_bit = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  lfsr_prbs dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_seed_in(seed_in),
    .o_state(state_a), .o_prbs_out(prbs_a), .o_lockup(lockup_a),
`ifdef LFSR_ERR_INJECT_EN
    .i_inject(1'b0),
`endif
    .i_rx_bit(rx_bit), .i_rx_valid(rx_valid), .i_clr_err(clr_err),
    .o_synced(synced_a), .o_err_pulse(pulse_a), .o_err_count(cnt_a)
  );

  lfsr_prbs #(.ERR_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load), .i_seed_in(seed_in),
    .o_state(state_b), .o_prbs_out(prbs_b), .o_lockup(lockup_b),
`ifdef LFSR_ERR_INJECT_EN
    .i_inject(1'b0),
`endif
    .i_rx_bit(rx_bit), .i_rx_valid(rx_valid), .i_clr_err(clr_err),
    .o_synced(synced_b), .o_err_pulse(pulse_b), .o_err_count(cnt_b)
  );

  // ---------------- reference model ----------------
  logic [3:0] m_state;
  bit         m_lock;
  bit         m_hist[$];   // recent stream bits, newest last
  int         m_phase;     // 0 hunting, 1 verifying, 2 locked
  int         m_fill, m_match, m_miss, m_errs;
  bit         m_synced, m_pulse;

  task automatic model_reset();
    m_state = SEED; m_lock = 0; m_hist.delete();
    m_phase = 0; m_fill = 0; m_match = 0; m_miss = 0; m_errs = 0;
    m_synced = 0; m_pulse = 0;
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit predict();
    bit p = 0;
    for (int i = 0; i < W; i++)
      if (TAPS[i]) p ^= m_hist[m_hist.size() - 1 - i];
    return p;
  endfunction

  function automatic bit last_w_zero();
    for (int i = 0; i < W; i++)
      if (m_hist[m_hist.size() - 1 - i]) return 0;
    return 1;
  endfunction

  task automatic model_step();
    int fb;
    bit p;
    m_lock = 0;
    if (load) m_state = seed_in;
    else if (m_state == 0) begin m_state = SEED; m_lock = 1; end
    else if (en) begin
      fb = $countones(m_state & TAPS) % 2;
      m_state = 4'(((m_state * 2) % 16) + fb);
    end
    m_pulse = 0;
    if (clr_err) m_errs = 0;
    if (rx_valid) begin
      if (m_phase == 0) begin
        m_hist.push_back(rx_bit);
        m_fill++;
        if (m_fill == W) begin m_phase = 1; m_match = 0; end
      end else if (m_phase == 1) begin
        p = predict();
        m_hist.push_back(rx_bit);
        if (rx_bit != p || last_w_zero()) begin m_phase = 0; m_fill = 0; end
        else begin
          m_match++;
          if (m_match == SYNC_LEN) begin m_phase = 2; m_synced = 1; m_miss = 0; end
        end
      end else begin
        p = predict();
        m_hist.push_back(p);
        if (rx_bit != p) begin
          if (!clr_err) begin m_errs++; m_pulse = 1; end
          m_miss++;
          if (m_miss == LOSS_THR) begin m_phase = 0; m_synced = 0; m_fill = 0; end
        end else m_miss = 0;
      end
    end
    while (m_hist.size() > W) void'(m_hist.pop_front());
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    rx_bit = loopback ? (prbs_a ^ flip) : force_bit;
    @(posedge clk);
    model_step();
    #1;
    check("state", state_a, m_state);
    check("prbs_out", prbs_a, m_state[3]);
    check("lockup", lockup_a, m_lock);
    check("synced", synced_a, m_synced);
    check("synced_b", synced_b, m_synced);
    check("err_pulse", pulse_a, m_pulse);
    check("err_count", cnt_a, sat(m_errs, 65535));
    check("err_count_sat", cnt_b, sat(m_errs, 15));
  endtask

  logic [3:0] exp_seq [15];
  int nvalid;

  initial begin
    exp_seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    model_reset();
    #12;
    check("rst_state", state_a, 4'b0001);
    check("rst_prbs", prbs_a, 1'b0);
    check("rst_lockup", lockup_a, 1'b0);
    check("rst_synced", synced_a, 1'b0);
    check("rst_pulse", pulse_a, 1'b0);
    check("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;

    // full period with gapless loopback; sync after 12 valid bits
    en = 1; rx_valid = 1; loopback = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("seq", state_a, exp_seq[i]);
      if (i == 10) check("sync_not_yet", synced_a, 1'b0);
      if (i == 11) check("sync_at_12", synced_a, 1'b1);
    end

    // long loopback with random rx_valid gaps, generator gated alongside
    for (int i = 0; i < 1000; i++) begin
      rx_valid = 1'($urandom_range(0, 1)); en = rx_valid;
      tick();
    end
    check("loop_no_err", cnt_a, 0);
    check("loop_synced", synced_a, 1'b1);

    // single flipped bit
    rx_valid = 1; en = 1; flip = 1;
    tick();
    flip = 0;
    check("single_pulse", pulse_a, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("single_cnt", cnt_a, 1);
    check("single_synced", synced_a, 1'b1);
    clr_err = 1; tick(); clr_err = 0;
    check("clr_cnt", cnt_a, 0);

    // LOSS_THR consecutive errors drop sync
    flip = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) check("loss_still_sync", synced_a, 1'b1);
    end
    flip = 0;
    check("loss_cnt", cnt_a, 4);
    check("loss_synced", synced_a, 1'b0);

    // resync with random gaps: 12 valid bits
    nvalid = 0;
    for (int i = 0; i < 200 && !synced_a; i++) begin
      rx_valid = 1'($urandom_range(0, 1)); en = rx_valid;
      if (rx_valid) nvalid++;
      tick();
    end
    check("resync_synced", synced_a, 1'b1);
    check("resync_bits", nvalid, 12);

    // saturation: alternate errors so sync holds, 20 errors total
    rx_valid = 1; en = 1;
    clr_err = 1; tick(); clr_err = 0;
    for (int i = 0; i < 40; i++) begin
      flip = (i % 2 == 0);
      tick();
    end
    flip = 0;
    check("sat_cnt_a", cnt_a, 20);
    check("sat_cnt_b", cnt_b, 15);
    check("sat_synced", synced_a, 1'b1);

    // seed load and zero recovery
    loopback = 0; rx_valid = 0; en = 0;
    load = 1; seed_in = 4'b0000; tick(); load = 0;
    check("load_zero", state_a, 4'b0000);
    tick();
    check("recover_state", state_a, 4'b0001);
    check("recover_lockup", lockup_a, 1'b1);
    tick();
    check("lockup_once", lockup_a, 1'b0);
    load = 1; en = 1; seed_in = 4'b1010; tick(); load = 0;
    check("load_over_en", state_a, 4'b1010);

    // randomized loopback with rare flips and loads
    loopback = 1;
    for (int i = 0; i < 1500; i++) begin
      rx_valid = 1'($urandom_range(0, 3) != 0); en = rx_valid;
      flip = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 199) == 0);
      seed_in = 4'($urandom_range(0, 15));
      clr_err = ($urandom_range(0, 99) == 0);
      tick();
    end
    // fully random inputs
    loopback = 0; flip = 0;
    for (int i = 0; i < 500; i++) begin
      rx_valid = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
      force_bit = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 31) == 0);
      seed_in = 4'($urandom_range(0, 15));
      clr_err = ($urandom_range(0, 49) == 0);
      tick();
    end
    load = 0; clr_err = 0;

    // asynchronous reset mid-operation
    loopback = 1; rx_valid = 1; en = 1;
    for (int i = 0; i < 20; i++) tick();
    flip = 1; tick(); flip = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_state", state_a, 4'b0001);
    check("arst_synced", synced_a, 1'b0);
    check("arst_cnt", cnt_a, 0);
    check("arst_cnt_b", cnt_b, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("post_arst_synced", synced_a, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs.md
# lfsr_prbs

Parametrised Fibonacci LFSR pattern generator paired with an independent PRBS checker, both in a single clock domain. The generator produces a configurable-width, configurable-polynomial bit stream with seed load, enable gating and automatic all-zero lock-up recovery. The checker synchronises to an incoming stream of the same polynomial, counts bit errors, and declares or drops sync. It is the general successor of the fixed 4-bit LFSR and serves as the link-test and BIST source/sink for the datapath.

## Interface
- WIDTH, 4: LFSR length in bits, 3..32.
- TAPS, 4'b1100: feedback mask; bit i set means s[i] feeds the XOR.
- SEED, 4'b0001: non-zero reset and recovery state.
- SYNC_LEN, 8: consecutive predicted-bit matches required to declare sync.
- LOSS_THR, 4: consecutive mismatches while locked that drop sync.
- ERR_W, 16: error counter width.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  generator advance enable.
- load  in  1  load seed_in into generator state.
- seed_in  in  WIDTH  value for load.
- state  out  WIDTH  generator state register.
- prbs_out  out  1  generator serial output.
- lockup  out  1  one-cycle pulse on zero-state recovery.
- rx_bit  in  1  checker input bit.
- rx_valid  in  1  rx_bit qualifier.
- clr_err  in  1  synchronous clear of err_count.
- synced  out  1  checker locked.
- err_pulse  out  1  one-cycle pulse per counted error.
- err_count  out  ERR_W  saturating error count.

## Operation
- Step function: fb = XOR-reduce(s & TAPS); next(s) = {s[WIDTH-2:0], fb}. prbs_out = s[WIDTH-1], combinational from state.
- Generator priority per cycle: load, then zero recovery, then en. load=1: state <= seed_in, regardless of en. Otherwise state==0: state <= SEED, lockup=1 for that cycle. Otherwise en=1: state <= next(state). Otherwise hold.
- A zero seed_in is accepted and recovered on the following cycle.
- Checker register chk[WIDTH-1:0], FSM HUNT / VERIFY / LOCKED. It acts only on cycles with rx_valid=1 and holds all state otherwise.
- HUNT: chk <= {chk[WIDTH-2:0], rx_bit}, fill counter +1. After WIDTH bits, go to VERIFY with the match counter at 0.
- VERIFY: predicted = fb(chk); chk <= {chk[WIDTH-2:0], rx_bit}. On a match, match counter +1; at SYNC_LEN go to LOCKED and set synced=1. On a mismatch, go to HUNT with fill counter 0 and chk keeping the shifted value. If chk becomes all zero, go to HUNT.
- LOCKED: chk <= next(chk), free-running reference that ignores rx_bit. On rx_bit != predicted: err_pulse=1, err_count +1 (saturating at all-ones), miss counter +1. On a match, miss counter clears. When the miss counter reaches LOSS_THR: synced=0, go to HUNT. The LOSS_THR-th mismatch is itself counted.
- Errors are counted only in LOCKED.
- clr_err=1: err_count <= 0. A simultaneous error is dropped.

## Timing
- Reset values: state=SEED, prbs_out=SEED[WIDTH-1], lockup=0, synced=0, err_pulse=0, err_count=0, FSM=HUNT, all internal counters 0.
- Generator: state and prbs_out change one clock after en/load is sampled; zero latency from state to prbs_out.
- Checker: synced rises at the clock that samples the SYNC_LEN-th matching valid bit. Minimum from reset is WIDTH+SYNC_LEN valid bits.
- err_pulse asserts in the cycle after the erroneous bit is sampled; err_count updates on the same edge.
- Reset asserted mid-operation forces all reset values immediately, independent of clock.

## Configuration
- LFSR_ERR_INJECT_EN defined: adds input port inject (1 bit). When inject=1 and en=1, prbs_out is inverted for that cycle only; state is unaffected.
- LFSR_ERR_INJECT_EN undefined: the inject port is absent; prbs_out = state[WIDTH-1] always.

## Test plan
- Defaults, en=1 from reset: state runs 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, then returns to 0001 after exactly 15 cycles; lockup never asserts.
- load=1 with seed_in=0000 -> state=0000 for one cycle, then 0001 with lockup=1 for one cycle. load and en high together with seed_in=1010 -> state=1010.
- prbs_out looped to rx_bit, rx_valid=1 -> synced=1 after 12 valid bits (WIDTH=4, SYNC_LEN=8); err_count stays 0 over 1000 cycles.
- Locked loopback, one prbs_out bit flipped by the inject macro or by the bench -> exactly one err_pulse, err_count=1, synced stays 1. clr_err -> err_count=0.
- Locked loopback, rx_bit forced to the inverse for 4 valid bits -> err_count=4, synced=0 after the 4th bit. Released -> resync after 12 valid bits.
- rx_valid toggling 1/0 during HUNT and LOCKED -> behaviour identical to the gapless case, delayed only by the idle cycles. ERR_W=4 with 20 forced errors -> err_count saturates at 15.
